// File: rtl/dpd_pkg.sv
// rtl/dpd_pkg.sv - shared constants and helpers for the DPD magnitude/address path
//
// Contents:
//   EXTRA_BITS   headroom bits on the alpha-max-beta-min magnitude
//   IQ_I_IDX/Q   packing order of a complex sample: x = {Q,I}, I in the low half
//   mag_shift    quantiser shift for the linear magnitude
//   mag2_shift   quantiser shift for the squared magnitude (DPD_MAG_SQUARED_EN)
//   tap_src      maps tap j and output phase to a history pair lag and phase
package dpd_pkg;

  localparam int EXTRA_BITS = 1;
  localparam int IQ_I_IDX   = 0;
  localparam int IQ_Q_IDX   = 1;

  function automatic int mag_shift(input int sw, input int aw);
    return sw - 1 - aw;
  endfunction

  function automatic int mag2_shift(input int sw, input int aw);
    return 2 * sw - 2 - aw;
  endfunction

  typedef struct packed {
    logic [7:0] lag;        // pair lag behind the newest pair
    logic       from_even;  // take the even-phase address of that pair
  } tap_src_t;

  // Tap j of sample s(2k) (even_out=0) or s(2k+1) (even_out=1).
  // Odd j crosses the pair boundary, so the phases swap.
  function automatic tap_src_t tap_src(input int j, input logic even_out);
    tap_src_t s;
    s.lag       = 8'(j / 2);
    s.from_even = even_out;
    if ((j % 2) == 1) begin
      if (even_out) begin
        s.from_even = 1'b0;
      end else begin
        s.lag       = 8'(j / 2 + 1);
        s.from_even = 1'b1;
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/dpd_mag_quant.sv
// rtl/dpd_mag_quant.sv - single-sample magnitude estimate and LUT address quantiser
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear of the pipeline registers
//   x           {Q,I} signed sample
//   addr        quantised address, combinational from the stage-2 register;
//               the parent registers it as the third stage
//
// Build option DPD_MAG_SQUARED_EN: defined uses I*I + Q*Q, otherwise
// the multiplier-free alpha-max-beta-min estimate.
module dpd_mag_quant
  import dpd_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic [2*SAMPLE_WIDTH-1:0] x,
  output logic [ADDR_WIDTH-1:0]     addr
);

  localparam int SW = SAMPLE_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] ADDR_MAX = '1;
`ifdef DPD_MAG_SQUARED_EN
  localparam int S1W   = 2 * SW;
  localparam int MW    = 2 * SW + 1;
  localparam int SHIFT = mag2_shift(SW, AW);
`else
  localparam int S1W   = SW;
  localparam int MW    = SW + EXTRA_BITS;
  localparam int SHIFT = mag_shift(SW, AW);
`endif

  logic signed [SW-1:0] i_s, q_s;
  logic [SW-1:0]        abs_i, abs_q;
  logic [S1W-1:0]       a_d, a_q, b_d, b_q;
  logic [MW-1:0]        mag_d, mag_q;
  logic [MW-1:0]        shifted;

  assign i_s = x[IQ_I_IDX*SW +: SW];
  assign q_s = x[IQ_Q_IDX*SW +: SW];

  // Unsigned result, so the most negative value maps to 2^(SW-1).
  assign abs_i = i_s[SW-1] ? SW'(-i_s) : SW'(i_s);
  assign abs_q = q_s[SW-1] ? SW'(-q_s) : SW'(q_s);

`ifdef DPD_MAG_SQUARED_EN
  always_comb begin
    a_d   = S1W'(abs_i) * S1W'(abs_i);
    b_d   = S1W'(abs_q) * S1W'(abs_q);
    mag_d = MW'(a_q) + MW'(b_q);
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      mag_d = '0;
    end
  end
`else
  logic [SW-1:0] mx, mn;

  always_comb begin
    a_d   = abs_i;
    b_d   = abs_q;
    mx    = (a_q >= b_q) ? a_q : b_q;
    mn    = (a_q >= b_q) ? b_q : a_q;
    // mx - mx/8 + mn/2 peaks at 1.375*2^(SW-1), inside SW+1 bits.
    mag_d = MW'(mx) - MW'(mx >> 3) + MW'(mn >> 1);
    if (clr) begin
      a_d   = '0;
      b_d   = '0;
      mag_d = '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      mag_q <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      mag_q <= mag_d;
    end
  end

  assign shifted = mag_q >> SHIFT;
  assign addr    = (shifted > MW'(ADDR_MAX)) ? ADDR_MAX : shifted[AW-1:0];

endmodule

// File: rtl/dpd_mag_addr_gen.sv
// rtl/dpd_mag_addr_gen.sv - dual-phase magnitude/address generator with j-delay taps
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr             synchronous clear of pipeline, history, fill count and taps
//   in_valid        x_odd/x_even carry a valid pair
//   x_odd, x_even   {Q,I} samples s(2k) and s(2k+1)
//   out_valid       taps updated this cycle (3 cycles after in_valid)
//   mag_odd_taps    slice j: address of s(2k-j)
//   mag_even_taps   slice j: address of s(2k+1-j)
//   tap_valid       bit j: tap j holds real history
//
// Build option DPD_MAG_SQUARED_EN selects the squared magnitude in dpd_mag_quant.
module dpd_mag_addr_gen
  import dpd_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int ADDR_WIDTH   = 3,
  parameter int J_DELAY_MAX  = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic                            in_valid,
  input  logic [2*SAMPLE_WIDTH-1:0]       x_odd,
  input  logic [2*SAMPLE_WIDTH-1:0]       x_even,
  output logic                            out_valid,
  output logic [J_DELAY_MAX*ADDR_WIDTH-1:0] mag_odd_taps,
  output logic [J_DELAY_MAX*ADDR_WIDTH-1:0] mag_even_taps,
  output logic [J_DELAY_MAX-1:0]          tap_valid
);

  localparam int AW    = ADDR_WIDTH;
  localparam int JD    = J_DELAY_MAX;
  localparam int DEPTH = JD / 2 + 1;
  localparam int CW    = $clog2(JD + 1);

  logic [AW-1:0]      addr_odd, addr_even;
  logic [1:0]         vld_d, vld_q;
  logic               push;
  logic [AW-1:0]      hist_odd_d [DEPTH];
  logic [AW-1:0]      hist_odd_q [DEPTH];
  logic [AW-1:0]      hist_even_d[DEPTH];
  logic [AW-1:0]      hist_even_q[DEPTH];
  logic [CW-1:0]      pairs_d, pairs_q;
  logic [JD*AW-1:0]   odd_sel, even_sel;
  logic [JD*AW-1:0]   odd_taps_d, odd_taps_q, even_taps_d, even_taps_q;
  logic [JD-1:0]      tap_valid_d, tap_valid_q;
  logic               out_valid_d, out_valid_q;

  dpd_mag_quant #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ADDR_WIDTH(AW)) u_quant_odd (
    .clk(clk), .rst_n(rst_n), .clr(clr), .x(x_odd), .addr(addr_odd)
  );

  dpd_mag_quant #(.SAMPLE_WIDTH(SAMPLE_WIDTH), .ADDR_WIDTH(AW)) u_quant_even (
    .clk(clk), .rst_n(rst_n), .clr(clr), .x(x_even), .addr(addr_even)
  );

  // Stage-2 valid qualifies the quantiser address; pushing it is stage 3.
  assign push = vld_q[1] & ~clr;

  // Tap selection reads the post-push history so taps and history agree.
  for (genvar j = 0; j < JD; j++) begin : g_tap
    localparam tap_src_t SO = tap_src(j, 1'b0);
    localparam tap_src_t SE = tap_src(j, 1'b1);
    localparam int       LO = int'(SO.lag);
    localparam int       LE = int'(SE.lag);
    assign odd_sel[j*AW +: AW]  = SO.from_even ? hist_even_d[LO] : hist_odd_d[LO];
    assign even_sel[j*AW +: AW] = SE.from_even ? hist_even_d[LE] : hist_odd_d[LE];
  end

  always_comb begin
    vld_d       = clr ? 2'b00 : {vld_q[0], in_valid};
    hist_odd_d  = hist_odd_q;
    hist_even_d = hist_even_q;
    pairs_d     = pairs_q;
    odd_taps_d  = odd_taps_q;
    even_taps_d = even_taps_q;
    tap_valid_d = tap_valid_q;
    out_valid_d = push;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        hist_odd_d[i]  = '0;
        hist_even_d[i] = '0;
      end
      pairs_d     = '0;
      odd_taps_d  = '0;
      even_taps_d = '0;
      tap_valid_d = '0;
    end else if (push) begin
      hist_odd_d[0]  = addr_odd;
      hist_even_d[0] = addr_even;
      for (int i = 1; i < DEPTH; i++) begin
        hist_odd_d[i]  = hist_odd_q[i-1];
        hist_even_d[i] = hist_even_q[i-1];
      end
      if (pairs_q != CW'(JD)) pairs_d = pairs_q + 1'b1;
      odd_taps_d  = odd_sel;
      even_taps_d = even_sel;
      for (int j = 0; j < JD; j++) begin
        tap_valid_d[j] = (2 * int'(pairs_d)) >= (j + 2);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        hist_odd_q[i]  <= '0;
        hist_even_q[i] <= '0;
      end
      pairs_q     <= '0;
      odd_taps_q  <= '0;
      even_taps_q <= '0;
      tap_valid_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      hist_odd_q  <= hist_odd_d;
      hist_even_q <= hist_even_d;
      pairs_q     <= pairs_d;
      odd_taps_q  <= odd_taps_d;
      even_taps_q <= even_taps_d;
      tap_valid_q <= tap_valid_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign mag_odd_taps  = odd_taps_q;
  assign mag_even_taps = even_taps_q;
  assign tap_valid     = tap_valid_q;

endmodule

// File: tb/tb_dpd_mag_addr_gen.sv
// tb/tb_dpd_mag_addr_gen.sv - directed self-checking bench for dpd_mag_addr_gen
module tb_dpd_mag_addr_gen;

  localparam int SW = 16;
  localparam int AW = 3;
  localparam int JD = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clr = 1'b0;
  logic            in_valid = 1'b0;
  logic [2*SW-1:0] x_odd = '0;
  logic [2*SW-1:0] x_even = '0;
  logic            out_valid;
  logic [JD*AW-1:0] mag_odd_taps, mag_even_taps;
  logic [JD-1:0]   tap_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dpd_mag_addr_gen #(.SAMPLE_WIDTH(SW), .ADDR_WIDTH(AW), .J_DELAY_MAX(JD)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid),
    .x_odd(x_odd), .x_even(x_even), .out_valid(out_valid),
    .mag_odd_taps(mag_odd_taps), .mag_even_taps(mag_even_taps), .tap_valid(tap_valid)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*SW-1:0] pk(input int i, input int q);
    logic [2*SW-1:0] r;
    r = {q[SW-1:0], i[SW-1:0]};
    return r;
  endfunction

  // Reference stream: sample n has I = 4682*(n mod 7), address n mod 7.
  function automatic logic [2*SW-1:0] samp(input int n);
    return pk(4682 * (n % 7), 0);
  endfunction

  function automatic int ea(input int n);
    return (n < 0) ? 0 : (n % 7);
  endfunction

  function automatic logic [JD*AW-1:0] exp_odd(input int p);
    logic [JD*AW-1:0] r;
    for (int j = 0; j < JD; j++) r[j*AW +: AW] = AW'(ea(2 * p - j));
    return r;
  endfunction

  function automatic logic [JD*AW-1:0] exp_even(input int p);
    logic [JD*AW-1:0] r;
    for (int j = 0; j < JD; j++) r[j*AW +: AW] = AW'(ea(2 * p + 1 - j));
    return r;
  endfunction

  function automatic logic [JD-1:0] exp_tv(input int pairs);
    logic [JD-1:0] r;
    int n;
    n = (pairs > JD) ? JD : pairs;
    for (int j = 0; j < JD; j++) r[j] = (2 * n) >= (j + 2);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    x_odd = pk(1000, 2000);
    x_even = pk(-3000, 5);
    repeat (4) step();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++;
    if (mag_odd_taps !== '0 || mag_even_taps !== '0) begin
      errors++; $display("FAIL reset_taps got %h/%h want 0/0", mag_odd_taps, mag_even_taps);
    end
    checks++;
    if (tap_valid !== '0) begin errors++; $display("FAIL reset_tap_valid got %b want 0", tap_valid); end
    rst_n = 1'b1;
    x_odd = pk(32767, 0);
    x_even = pk(16384, 0);
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      checks++;
      if (out_valid !== (c == 3)) begin
        errors++; $display("FAIL first_latency cycle %0d got %b want %b", c, out_valid, (c == 3));
      end
      if (c == 3) begin
        checks++;
        if (tap_valid !== 8'b0000_0001) begin
          errors++; $display("FAIL first_tap_valid got %b want 00000001", tap_valid);
        end
        checks++;
        if (mag_odd_taps[AW-1:0] !== 3'd7 || mag_even_taps[AW-1:0] !== 3'd3) begin
          errors++; $display("FAIL first_addr got %0d/%0d want 7/3", mag_odd_taps[AW-1:0], mag_even_taps[AW-1:0]);
        end
      end
      if (c < 4) step();
    end
  endtask

  task automatic test_quant();
    int vi_o[5] = '{8192, 0, -32768, 16384, 32767};
    int vq_o[5] = '{8192, 0, -32768, 0, 0};
    int vi_e[5] = '{-32768, 32767, 8192, 0, 16384};
    int vq_e[5] = '{-32768, 0, 8192, 0, 0};
    int ao[5]   = '{2, 0, 7, 3, 7};
    int ae[5]   = '{7, 7, 2, 0, 3};
    for (int t = 0; t < 5; t++) begin
      x_odd = pk(vi_o[t], vq_o[t]);
      x_even = pk(vi_e[t], vq_e[t]);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      checks++;
      if (out_valid !== 1'b1 || mag_odd_taps[AW-1:0] !== AW'(ao[t]) || mag_even_taps[AW-1:0] !== AW'(ae[t])) begin
        errors++;
        $display("FAIL quant_%0d got v=%b %0d/%0d want v=1 %0d/%0d", t, out_valid,
                 mag_odd_taps[AW-1:0], mag_even_taps[AW-1:0], ao[t], ae[t]);
      end
    end
  endtask

  task automatic test_delay_map();
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i < 10) begin
        in_valid = 1'b1;
        x_odd = samp(2 * i);
        x_even = samp(2 * i + 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      checks++;
      if (out_valid !== (i >= 2)) begin
        errors++; $display("FAIL map_out_valid i=%0d got %b want %b", i, out_valid, (i >= 2));
      end
      if (i >= 2) begin
        checks++;
        if (mag_odd_taps !== exp_odd(i - 2) || mag_even_taps !== exp_even(i - 2)) begin
          errors++;
          $display("FAIL map_taps pair=%0d got %h/%h want %h/%h", i - 2, mag_odd_taps,
                   mag_even_taps, exp_odd(i - 2), exp_even(i - 2));
        end
        checks++;
        if (tap_valid !== exp_tv(i - 1)) begin
          errors++; $display("FAIL map_tap_valid pair=%0d got %b want %b", i - 2, tap_valid, exp_tv(i - 1));
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    int next_pair = 10;
    int shown = 9;
    for (int i = 0; i < 7; i++) begin
      in_valid = pat[i];
      if (pat[i]) begin
        x_odd = samp(2 * next_pair);
        x_even = samp(2 * next_pair + 1);
        next_pair++;
      end
      step();
      if (i >= 2 && pat[i-2]) shown++;
      checks++;
      if (out_valid !== (i >= 2 && pat[i-2])) begin
        errors++; $display("FAIL gap_out_valid i=%0d got %b want %b", i, out_valid, (i >= 2 && pat[i-2]));
      end
      checks++;
      if (mag_odd_taps !== exp_odd(shown) || mag_even_taps !== exp_even(shown) || tap_valid !== 8'hFF) begin
        errors++;
        $display("FAIL gap_taps i=%0d got %h/%h/%b want %h/%h/11111111", i, mag_odd_taps,
                 mag_even_taps, tap_valid, exp_odd(shown), exp_even(shown));
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_clr();
    in_valid = 1'b1;
    x_odd = samp(24);
    x_even = samp(25);
    step();
    x_odd = samp(26);
    x_even = samp(27);
    clr = 1'b1;
    step();
    clr = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || mag_odd_taps !== '0 || mag_even_taps !== '0 || tap_valid !== '0) begin
      errors++;
      $display("FAIL clr_state got %b %h/%h/%b want 0 0/0/0", out_valid, mag_odd_taps, mag_even_taps, tap_valid);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0 || tap_valid !== '0) begin
        errors++; $display("FAIL clr_flush c=%0d got %b/%b want 0/0", c, out_valid, tap_valid);
      end
    end
    in_valid = 1'b1;
    x_odd = samp(5);
    x_even = samp(3);
    step();
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b1 || tap_valid !== 8'b0000_0001) begin
      errors++; $display("FAIL clr_first got %b/%b want 1/00000001", out_valid, tap_valid);
    end
    checks++;
    if (mag_odd_taps !== 24'h000005 || mag_even_taps !== 24'h00002B) begin
      errors++; $display("FAIL clr_first_taps got %h/%h want 000005/00002b", mag_odd_taps, mag_even_taps);
    end
  endtask

  task automatic test_squared();
    logic [AW-1:0] want_mid;
`ifdef DPD_MAG_SQUARED_EN
    want_mid = 3'd4;
`else
    want_mid = 3'd5;
`endif
    in_valid = 1'b1;
    x_odd = pk(16384, 16384);
    x_even = pk(-32768, -32768);
    step();
    in_valid = 1'b0;
    step();
    step();
    checks++;
    if (mag_odd_taps[AW-1:0] !== want_mid) begin
      errors++; $display("FAIL mag_mode_mid got %0d want %0d", mag_odd_taps[AW-1:0], want_mid);
    end
    checks++;
    if (mag_even_taps[AW-1:0] !== 3'd7) begin
      errors++; $display("FAIL mag_mode_full got %0d want 7", mag_even_taps[AW-1:0]);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    x_odd = samp(4);
    x_even = samp(6);
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || mag_odd_taps !== '0 || mag_even_taps !== '0 || tap_valid !== '0) begin
      errors++;
      $display("FAIL async_reset got %b %h/%h/%b want all 0", out_valid, mag_odd_taps, mag_even_taps, tap_valid);
    end
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL async_reset_partial c=%0d got %b want 0", c, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_quant();
    test_delay_map();
    test_gaps();
    test_clr();
    test_squared();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpd_mag_addr_gen.md
Name: dpd_mag_addr_gen

Overview:
Upstream feeder for the DPD LUT rows. It takes two complex samples per clock (odd/even phase) and computes a magnitude estimate for each. It quantises each magnitude to a LUT address and keeps a sample-granular history. Each of the J_DELAY_MAX row instances receives its own mag_odd/mag_even pair at its j-delay.

Parameters:
SAMPLE_WIDTH, 16, signed width of each I and Q component
ADDR_WIDTH, 3, LUT address width; must match the LUT rows
J_DELAY_MAX, 8, number of delay taps (j = 0..J_DELAY_MAX-1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of pipeline and history
in_valid  in  1  x_odd/x_even carry a valid sample pair
x_odd  in  2*SAMPLE_WIDTH  {Q,I}, sample s(2k)
x_even  in  2*SAMPLE_WIDTH  {Q,I}, sample s(2k+1)
out_valid  in→out  out  1  tap outputs updated this cycle
mag_odd_taps  out  J_DELAY_MAX*ADDR_WIDTH  tap j in slice j: address of s(2k-j)
mag_even_taps  out  J_DELAY_MAX*ADDR_WIDTH  tap j in slice j: address of s(2k+1-j)
tap_valid  out  J_DELAY_MAX  tap j holds real history, not fill zeros

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n). All pipeline registers, the history, the fill counter and every output clear to 0.
- Stage 1 (registered): |I|, |Q| as unsigned SAMPLE_WIDTH bits, so -32768 gives 32768.
- Stage 2 (registered): mx = max, mn = min; mag = mx - (mx>>3) + (mn>>1), SAMPLE_WIDTH+1 bits, no overflow.
- Stage 3 (registered): addr = mag >> (SAMPLE_WIDTH-1-ADDR_WIDTH), saturated to 2^ADDR_WIDTH-1.
- Valid bit travels with each stage. The pipeline advances every clock. Latency in_valid → out_valid is 3 cycles.
- History register: pairs of addresses, depth floor(J_DELAY_MAX/2)+1 including the current pair. It shifts only when the stage-3 valid is 1; gaps in in_valid insert no samples.
- Tap mapping in pair-lag units, where k is the newest pair:
  - j even = 2m: odd = odd[k-m], even = even[k-m].
  - j odd = 2m+1: odd = even[k-m-1], even = odd[k-m].
- Tap outputs are registered. They update in the same cycle that out_valid is 1 and hold otherwise.
- Fill counter: counts pairs pushed, saturating at J_DELAY_MAX. tap_valid[j] = (2*pairs ≥ j+2).
- Slots never written read as address 0.
- clr takes priority over in_valid and over stage valids in the same cycle. It zeroes the valids, the history, the fill counter, the taps and tap_valid. The next valid pair after clr behaves as the first pair after reset.
- rst_n asserted mid-stream clears everything immediately; no partial output is produced.

Optional Feature:
DPD_MAG_SQUARED_EN
- Defined: stages 1–2 compute mag2 = I*I + Q*Q (2*SAMPLE_WIDTH+1 bits, unsigned). Stage 3 computes addr = mag2 >> (2*SAMPLE_WIDTH-2-ADDR_WIDTH), saturated. Latency stays 3 cycles.
- Undefined: the alpha-max-beta-min path above is used and no multipliers are inferred.

Decomposition:
- Shared package dpd_pkg holds:
  - EXTRA_BITS;
  - the mag shift constants (MAG_SHIFT = SAMPLE_WIDTH-1-ADDR_WIDTH, MAG2_SHIFT);
  - the tap slice helper function;
  - the {Q,I} packing order.
- One sub-module, dpd_mag_quant: a single-sample 3-stage magnitude/quantiser, instantiated twice (odd and even). The top level owns the history, the fill counter and the tap mapping.

Test Plan:
- Reset: hold rst_n=0 while driving in_valid=1 and x≠0 → all outputs 0. Release, apply one pair → out_valid exactly 3 cycles after in_valid, tap_valid=8'b0000_0001.
- Quantiser, both phases: (I,Q) = (32767,0)→7; (16384,0)→3; (8192,8192)→2; (-32768,-32768)→7 (saturated); (0,0)→0.
- Delay mapping: stream samples with I = 4682*a, Q=0, addresses a = n mod 7 in sample order. At pair k, tap3 odd = addr(s(2k-3)) and tap3 even = addr(s(2k-2)); tap0 equals the current pair. After 8 pairs tap_valid=8'hFF.
- Gaps: in_valid pattern 1,0,0,1 → taps hold during the gap; the history advances by exactly 2 pairs; out_valid pulses twice.
- clr: assert clr together with in_valid mid-stream → next cycle taps=0, tap_valid=0. The next valid pair gives tap_valid=8'b0000_0001.
- DPD_MAG_SQUARED_EN: I=Q=16384 → addr 4 with the macro defined, 5 without. I=Q=-32768 → 7 in both builds.
